// File: rtl/move_seq_pkg.sv
// Shared types and constants for the move sequencer.
// MOVE_SEQ_STALL_EN (optional) enables the stall watchdog in move_sequencer.
package move_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RUN,
        STOP,
        DONE
    } seq_state_e;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_ABORT  = 2'b01;
    localparam logic [1:0] ST_STALL  = 2'b10;
    localparam logic [1:0] ST_REJECT = 2'b11;

    localparam logic [1:0] CLR_ALL   = 2'b11;

    // True when a leads b by more than tol; 17-bit sum so b + tol cannot wrap.
    function automatic logic leads(input logic [15:0] a, input logic [15:0] b,
                                   input int unsigned tol);
        return {1'b0, a} > ({1'b0, b} + 17'(tol));
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts cycles since either position input last changed; flags expiry while armed.
// Compiled only when MOVE_SEQ_STALL_EN is defined.
`ifdef MOVE_SEQ_STALL_EN
module stall_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic [15:0] pos_a,
    input  logic [15:0] pos_b,
    output logic        expired
);

    localparam logic [31:0] Limit = 32'(TIMEOUT_CYCLES - 1);

    logic [15:0] pos_a_q;
    logic [15:0] pos_b_q;
    logic [31:0] cnt_q;
    logic        moved;

    assign moved   = (pos_a != pos_a_q) || (pos_b != pos_b_q);
    assign expired = arm && !moved && (cnt_q >= Limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_a_q <= '0;
            pos_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            pos_a_q <= pos_a;
            pos_b_q <= pos_b;
            if (!arm || moved) begin
                cnt_q <= '0;
            end else if (cnt_q < Limit) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/move_sequencer.sv
// Sequences one straight two-motor move against the posManager counters.
// MOVE_SEQ_STALL_EN adds a RUN-state stall watchdog (status 10 on timeout).
module move_sequencer
    import move_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned BRAKE_CYCLES   = 16,
    parameter int unsigned BAL_TOL        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_dist,
    input  logic        abort,
    input  logic [15:0] pos12,
    input  logic [15:0] pos22,
    input  logic [31:0] count_clk,
    output logic [1:0]  clear,
    output logic        m1_en,
    output logic        m2_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] elapsed
);

    if (SETTLE_CYCLES == 0 || BRAKE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("move_sequencer: cycle parameters must be at least 1");
    end

    localparam logic [31:0] SettleLoad = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] BrakeLoad  = 32'(BRAKE_CYCLES - 1);

    seq_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] target_q, target_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] elapsed_q, elapsed_d;
    logic        done_cond_q;
    logic        stall_expired;

`ifdef MOVE_SEQ_STALL_EN
    stall_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .arm    (state_q == RUN),
        .pos_a  (pos12),
        .pos_b  (pos22),
        .expired(stall_expired)
    );
`else
    assign stall_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        status_d  = status_q;
        elapsed_d = elapsed_q;
        clear     = 2'b00;
        m1_en     = 1'b0;
        m2_en     = 1'b0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    target_d  = cmd_dist;
                    status_d  = ST_OK;
                    elapsed_d = '0;
                    if (cmd_dist[15]) begin
                        status_d = ST_REJECT;
                        state_d  = DONE;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                clear = CLR_ALL;
                if (abort) begin
                    status_d = ST_ABORT;
                    cnt_d    = BrakeLoad;
                    state_d  = STOP;
                end else begin
                    cnt_d   = SettleLoad;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    status_d = ST_ABORT;
                    cnt_d    = BrakeLoad;
                    state_d  = STOP;
                end else if (cnt_q == '0) begin
                    if (target_q == '0) begin
                        cnt_d   = BrakeLoad;
                        state_d = STOP;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RUN: begin
                m1_en = !leads(pos12, pos22, BAL_TOL);
                m2_en = !leads(pos22, pos12, BAL_TOL);
                // Priority: reaching target, then abort, then stall.
                if (done_cond_q || abort || stall_expired) begin
                    elapsed_d = count_clk;
                    cnt_d     = BrakeLoad;
                    state_d   = STOP;
                    if (done_cond_q) begin
                        status_d = ST_OK;
                    end else if (abort) begin
                        status_d = ST_ABORT;
                    end else begin
                        status_d = ST_STALL;
                    end
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            target_q    <= '0;
            status_q    <= ST_OK;
            elapsed_q   <= '0;
            done_cond_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            status_q    <= status_d;
            elapsed_q   <= elapsed_d;
            // Only meaningful in RUN, so a stale compare never ends a fresh move.
            done_cond_q <= (state_q == RUN) && (pos12 >= target_q) && (pos22 >= target_q);
        end
    end

    assign status  = status_q;
    assign elapsed = elapsed_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus randomized moves.
// Define MOVE_SEQ_STALL_EN to expect the stall watchdog behaviour.
module tb_move_sequencer;

    localparam int unsigned S   = 4;
    localparam int unsigned B   = 16;
    localparam int unsigned TOL = 2;
    localparam int unsigned TMO = 50;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ABT = 2'b01;
    localparam logic [1:0] STL = 2'b10;
    localparam logic [1:0] REJ = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, abort;
    logic [15:0] cmd_dist, pos12, pos22;
    logic [31:0] count_clk;
    logic [1:0]  clear, status;
    logic        m1_en, m2_en, busy, done;
    logic [31:0] elapsed;

    int checks = 0;
    int errors = 0;

    move_sequencer #(
        .SETTLE_CYCLES (S),
        .BRAKE_CYCLES  (B),
        .BAL_TOL       (TOL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dist (cmd_dist),
        .abort    (abort),
        .pos12    (pos12),
        .pos22    (pos22),
        .count_clk(count_clk),
        .clear    (clear),
        .m1_en    (m1_en),
        .m2_en    (m2_en),
        .busy     (busy),
        .done     (done),
        .status   (status),
        .elapsed  (elapsed)
    );

    always #5 clk = ~clk;

    // posManager clock counter: free-running, zeroed by clear[0].
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_clk <= '0;
        else if (clear[0]) count_clk <= '0;
        else count_clk <= count_clk + 32'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A motor may run unless it leads the other by more than TOL.
    function automatic logic en_model(input int unsigned a, input int unsigned b);
        return !(a > b + TOL);
    endfunction

    task automatic chk_idle(input logic [1:0] st, input logic [31:0] el);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_clear", clear, 0);
        chk("idle_en", {m1_en, m2_en}, 0);
        chk("idle_status", status, st);
        chk("idle_elapsed", elapsed, el);
    endtask

    // From the first STOP cycle through DONE back to IDLE.
    task automatic finish_move(input logic [1:0] st, input logic [31:0] el);
        for (int b = 0; b < B; b++) begin
            chk("stop_en", {m1_en, m2_en}, 0);
            chk("stop_done", done, 0);
            chk("stop_busy", busy, 1);
            if (b == 1) begin
                cmd_valid = 1'b1;
                cmd_dist  = 16'd5;
            end
            if (b == B / 2) abort = 1'b0;
            tick();
        end
        cmd_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_ready", cmd_ready, 0);
        chk("done_status", status, st);
        chk("done_elapsed", elapsed, el);
        tick();
        chk_idle(st, el);
    endtask

    // abort_at: -1 none, -2 in SETTLE, -3 same cycle as done_cond, >=0 RUN cycle index.
    task automatic do_move(input logic [15:0] tgt, input int abort_at, input bit frozen);
        int unsigned p1, p2;
        int          hit, trans;
        logic [1:0]  st;
        logic [31:0] el;
        bit          skip_run;
        p1 = 0; p2 = 0; hit = -1; trans = -1; st = OK; el = 0; skip_run = 0;
        chk("accept_ready", cmd_ready, 1);
        cmd_dist  = tgt;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        if (tgt[15]) begin
            chk("rej_clear", clear, 0);
            chk("rej_done", done, 1);
            chk("rej_busy", busy, 1);
            chk("rej_status", status, REJ);
            chk("rej_en", {m1_en, m2_en}, 0);
            tick();
            chk_idle(REJ, 0);
            return;
        end
        chk("clear_pulse", clear, 2'b11);
        chk("clear_busy", busy, 1);
        chk("clear_ready", cmd_ready, 0);
        pos12 = '0;
        pos22 = '0;
        tick();
        for (int s = 0; s < S; s++) begin
            chk("settle_clear", clear, 0);
            chk("settle_en", {m1_en, m2_en}, 0);
            chk("settle_cnt", count_clk, s);
            if (abort_at == -2 && s == 1) begin
                abort = 1'b1;
                st = ABT;
                skip_run = 1;
                tick();
                break;
            end
            tick();
        end
        if (tgt == 0) skip_run = 1;
        if (!skip_run) begin
            for (int k = 0; k < 200; k++) begin
                if (!frozen) begin
                    p1 += $urandom_range(0, 3);
                    p2 += ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 3);
                end
                if (abort_at >= 0 && k == abort_at) abort = 1'b1;
                if (abort_at == -3 && hit >= 0 && k == hit + 1) abort = 1'b1;
                pos12 = 16'(p1);
                pos22 = 16'(p2);
                #1;
                chk("run_busy", busy, 1);
                chk("run_m1", m1_en, en_model(p1, p2));
                chk("run_m2", m2_en, en_model(p2, p1));
                if (hit >= 0 && k == hit + 1) begin
                    trans = k; st = OK;
                end else if (abort) begin
                    trans = k; st = ABT;
                end
`ifdef MOVE_SEQ_STALL_EN
                else if (frozen && k == TMO - 1) begin
                    trans = k; st = STL;
                end
`endif
                if (hit < 0 && p1 >= tgt && p2 >= tgt) hit = k;
                if (trans >= 0) begin
                    el = S + k;
                    tick();
                    break;
                end
                tick();
            end
            chk("run_bound", (trans >= 0), 1);
        end
        finish_move(st, el);
    endtask

    initial begin
        logic [15:0] t;
        int          a;
        cmd_valid = 1'b0;
        cmd_dist  = '0;
        abort     = 1'b0;
        pos12     = '0;
        pos22     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle(OK, 0);
        rst_n = 1'b1;
        tick();

        do_move(16'd10, -1, 0);
        do_move(16'd37, -1, 0);

        // Balance gating, then abort in RUN cycle 2.
        cmd_dist = 16'd100; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
        pos12 = '0; pos22 = '0;
        repeat (S + 1) tick();
        pos12 = 16'd5; pos22 = 16'd2; #1;
        chk("bal_lead_m1", m1_en, 0);
        chk("bal_lead_m2", m2_en, 1);
        tick();
        pos22 = 16'd3; #1;
        chk("bal_tol_m1", m1_en, 1);
        chk("bal_tol_m2", m2_en, 1);
        tick();
        pos12 = 16'd3; pos22 = 16'd6; #1;
        chk("bal_rev_m1", m1_en, 1);
        chk("bal_rev_m2", m2_en, 0);
        abort = 1'b1;
        tick();
        finish_move(ABT, S + 2);

        // Asynchronous reset while in RUN.
        cmd_dist = 16'd50; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
        pos12 = '0; pos22 = '0;
        repeat (S + 1) tick();
        pos12 = 16'd1; pos22 = 16'd1; #1;
        chk("prerst_m1", m1_en, 1);
        chk("prerst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_idle(OK, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_ready", cmd_ready, 1);
        chk("postrst_busy", busy, 0);
        tick();

        do_move(16'h8000, -1, 0);
        do_move(16'd0, -1, 0);
        do_move(16'd30, -2, 0);
        do_move(16'd20, -3, 0);
        do_move(16'd100, 60, 1);

        for (int i = 0; i < 12; i++) begin
            t = 16'($urandom_range(1, 60));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            if ($urandom_range(0, 7) == 0) t = t | 16'h8000;
            do_move(t, a, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
